uart_peripheral: RTL
====================

// Module: uart_peripheral
// PURPOSE
//   Memory-mapped UART for the leorv32 SoC. Buffered successor to the single-register UART window.
//   Adds parametrised TX/RX FIFOs, a runtime-programmable baud divider, sticky error flags and
//   per-FIFO fill counts. Sits on the shared CPU memory bus behind the SoC address decoder,
//   which supplies sel. UART rx input must come through the 3-FF synchronizer.
// PARAMETERS
//   FREQUENCY   12_000_000  clk frequency in Hz
//   BAUDRATE    9600        reset baud; reset divider DIV_RESET = FREQUENCY/BAUDRATE (integer divide)
//   FIFO_DEPTH  8           entries per FIFO; power of 2, 2..128
// PORTS
//   clk        in   1   system clock
//   resetn     in   1   synchronous, active-low reset
//   sel        in   1   decoder hit for this peripheral this cycle
//   mem_addr   in   4   byte offset [3:0]; [1:0] ignored (word registers)
//   mem_wdata  in   32  write data
//   mem_wmask  in   4   byte write mask; any bit set with sel = write
//   mem_rstrb  in   1   read strobe; with sel = read
//   mem_rdata  out  32  read data, valid the cycle after mem_rstrb
//   uart_rx    in   1   synchronised serial input, idle high
//   uart_tx    out  1   serial output, idle high
//   irq        out  1   level interrupt (UART_IRQ_EN only)
// BEHAVIOUR
//   Reset: uart_tx=1, mem_rdata=0, irq=0, FIFOs empty, flags=0, divider=DIV_RESET, both FSMs IDLE.
//   Register map (offset):
//     0x0 DATA   W: push wdata[7:0] to TX FIFO. R: {rx_valid,23'b0,byte}; pops RX FIFO if non-empty,
//                else returns 0.
//     0x4 STATUS R: [0] rx_valid [1] tx_full [2] tx_idle (FIFO empty and shifter idle)
//                [3] rx_overrun [4] frame_err [5] tx_overflow [15:8] rx_count [23:16] tx_count.
//                W: 1 to bits [5:3] clears the corresponding sticky flag.
//     0x8 DIV    RW [15:0] clocks per bit; writes <4 stored as 4.
//     0xC IRQEN  RW [0] rx_valid [1] tx_idle [2] any error (reads 0 without UART_IRQ_EN).
//   Bus: writes take effect at the same edge. Reads are registered, so there is 1-cycle latency.
//     A DATA pop happens at the edge of the strobe cycle. No wait states.
//   TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
//     Each bit lasts DIV clks. A byte is popped from the FIFO on leaving IDLE.
//     Back-to-back bytes need no extra idle bit.
//   RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//     IDLE sees a falling edge and waits DIV/2 clks. If rx is high at mid-start, the FSM returns to
//     IDLE (glitch). It then samples each bit at mid-bit.
//     Stop bit 0: discard byte, set frame_err, wait for rx=1 before IDLE.
//   DIV latched per frame at frame start; mid-frame writes affect the next frame only.
//   Boundaries:
//     - DATA write while TX full: drop byte, set tx_overflow.
//     - RX byte complete while RX full: drop new byte, set rx_overrun.
//     - Push and pop on a full FIFO in the same cycle: both happen, count unchanged.
//     - Push and pop on an empty FIFO: pop sees empty, push lands.
//     - Error event and W1C clear in the same cycle: flag stays set.
//     - resetn low mid-frame: abort immediately, uart_tx=1 next cycle, FIFO contents lost.
// CONFIGURATION
//   UART_IRQ_EN defined:
//     irq = |(IRQEN & {err, tx_idle, rx_valid}), registered, 1-cycle lag; err = |flags[5:3].
//   UART_IRQ_EN undefined: no IRQEN storage, IRQEN reads 0, writes ignored, irq tied 0.
// STRUCTURE
//   Package uart_pkg:
//     - Register offset localparams (UART_DATA/STATUS/DIV/IRQEN).
//     - STATUS bit index localparams.
//     - enum uart_state_e {IDLE,START,DATA,STOP}.
//   Sub-module sync_fifo #(WIDTH,DEPTH):
//     - Ports push/pop/wdata/rdata/full/empty/count.
//     - Show-ahead read. Instantiated twice.
// TESTING (FREQUENCY=12_000_000, BAUDRATE=1_000_000 -> DIV=12)
//   1 Write DATA=0xA5 -> tx low 12 clks, then bits 1,0,1,0,0,1,0,1 at 12 clks each,
//     stop high; STATUS.tx_idle=1 after 120 clks.
//   2 Drive frame 0x3C on uart_rx -> STATUS.rx_valid=1, rx_count=1; DATA read = 0x8000003C;
//     next DATA read = 0x00000000.
//   3 Write 9 bytes with DEPTH=8 while idle -> first pops to shifter, 8 buffered, tx_full=1;
//     10th write dropped and tx_overflow=1; W1C 0x20 clears the flag.
//   4 Send 9 frames without reading -> rx_count=8, rx_overrun=1, DATA returns frames 1..8 in order.
//   5 Frame with stop bit 0 -> frame_err=1, rx_count unchanged. 1-clk low glitch on rx -> no frame.
//   6 Write DIV=2 -> reads 4. Write DIV=24 mid-frame -> current frame stays at 12 clks/bit,
//     next frame uses 24. With UART_IRQ_EN, IRQEN=1 -> irq rises 1 clk after rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, status bit positions and FSM states for uart_peripheral
package uart_pkg;

  // Byte offsets of the word registers
  localparam logic [3:0] UART_DATA   = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_DIV    = 4'h8;
  localparam logic [3:0] UART_IRQEN  = 4'hC;

  // STATUS bit positions
  localparam int ST_RX_VALID     = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_TX_IDLE      = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_FRAME_ERR    = 4;
  localparam int ST_TX_OVERFLOW  = 5;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;

  // Smallest usable divider: the receiver needs at least two clocks to reach mid-start
  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO, power-of-2 depth
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rptr_q];

  // A pop on empty is ignored; a push on full lands only if a pop frees a slot this cycle
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are meaningless once the pointers reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_peripheral.sv
// rtl/uart_peripheral.sv - buffered memory-mapped UART; UART_IRQ_EN adds IRQEN register and irq
module uart_peripheral #(
  parameter int FREQUENCY  = 12_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  import uart_pkg::*;

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DIV_RESET = clamp_div(16'(FREQUENCY / BAUDRATE));

  // Bus decode
  logic       bus_wr, bus_rd;
  logic [3:0] reg_off;
  assign bus_wr  = sel & (|mem_wmask);
  assign bus_rd  = sel & mem_rstrb;
  assign reg_off = {mem_addr[3:2], 2'b00};

  logic unused_bits;
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16]};

  // FIFO interfaces
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_fifo_rdata;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_fifo_rdata;
  logic [CW-1:0] rx_count;

  // Register state
  logic [15:0] div_q, div_d;
  logic [2:0]  flags_q, flags_d;     // {tx_overflow, frame_err, rx_overrun}
  logic [2:0]  flag_set, flag_clr;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] status_word, irqen_rd;
  logic        tx_idle, rx_valid;

  // TX FSM state
  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_out_q, tx_out_d, tx_bit_end;

  // RX FSM state
  uart_state_e rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half_m1;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_prev_q, rx_brk_q, rx_brk_d, rx_bit_end, rx_frame_err;

  assign tx_push = bus_wr & (reg_off == UART_DATA);
  assign rx_pop  = bus_rd & (reg_off == UART_DATA);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .push(tx_push), .pop(tx_pop), .wdata(mem_wdata[7:0]),
    .rdata(tx_fifo_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .push(rx_push), .pop(rx_pop), .wdata(rx_shift_q),
    .rdata(rx_fifo_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // TX shifter: the line level is registered from the next state so uart_tx never glitches
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);
    case (tx_state_q)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_fifo_rdata;
          tx_div_d   = div_q;
          tx_cnt_d   = '0;
          tx_state_d = START;
        end
      end
      START: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = DATA;
        end
      end
      DATA: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end
      end
      STOP: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_fifo_rdata;
            tx_div_d   = div_q;
            tx_state_d = START;
          end else begin
            tx_state_d = IDLE;
          end
        end
      end
      default: tx_state_d = IDLE;
    endcase
    case (tx_state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = tx_shift_d[0];
      default: tx_out_d = 1'b1;
    endcase
  end

  // RX sampler: mid-start qualification, then one sample per bit period
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_div_d     = rx_div_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_brk_d     = rx_brk_q;
    rx_push      = 1'b0;
    rx_frame_err = 1'b0;
    rx_half_m1   = {1'b0, rx_div_q[15:1]} - 16'd1;
    rx_bit_end   = (rx_cnt_q == rx_div_q - 16'd1);
    case (rx_state_q)
      IDLE: begin
        if (rx_prev_q && !uart_rx) begin
          rx_div_d   = div_q;
          rx_cnt_d   = '0;
          rx_state_d = START;
        end
      end
      START: begin
        rx_cnt_d = rx_cnt_q + 16'd1;
        if (rx_cnt_q == rx_half_m1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = uart_rx ? IDLE : DATA;
        end
      end
      DATA: begin
        rx_cnt_d = rx_cnt_q + 16'd1;
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {uart_rx, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
        end
      end
      STOP: begin
        if (rx_brk_q) begin
          // Bad stop bit: hold off until the line returns high
          if (uart_rx) begin
            rx_brk_d   = 1'b0;
            rx_state_d = IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
          if (rx_bit_end) begin
            rx_cnt_d = '0;
            if (uart_rx) begin
              rx_push    = 1'b1;
              rx_state_d = IDLE;
            end else begin
              rx_frame_err = 1'b1;
              rx_brk_d     = 1'b1;
            end
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // Register file: divider, sticky flags (set wins over clear), status and read mux
  always_comb begin
    rx_valid = ~rx_empty;
    tx_idle  = tx_empty & (tx_state_q == IDLE);
    div_d    = div_q;
    if (bus_wr && reg_off == UART_DIV) div_d = clamp_div(mem_wdata[15:0]);
    flag_set = {tx_push & tx_full & ~tx_pop, rx_frame_err, rx_push & rx_full & ~rx_pop};
    flag_clr = (bus_wr && reg_off == UART_STATUS) ? mem_wdata[5:3] : 3'b000;
    flags_d  = (flags_q & ~flag_clr) | flag_set;
    status_word = '0;
    status_word[ST_RX_VALID]    = rx_valid;
    status_word[ST_TX_FULL]     = tx_full;
    status_word[ST_TX_IDLE]     = tx_idle;
    status_word[ST_RX_OVERRUN]  = flags_q[0];
    status_word[ST_FRAME_ERR]   = flags_q[1];
    status_word[ST_TX_OVERFLOW] = flags_q[2];
    status_word[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);
    status_word[ST_TX_COUNT_LSB +: 8] = 8'(tx_count);
    rdata_d = rdata_q;
    if (bus_rd) begin
      case (reg_off)
        UART_DATA:   rdata_d = rx_valid ? {1'b1, 23'b0, rx_fifo_rdata} : 32'b0;
        UART_STATUS: rdata_d = status_word;
        UART_DIV:    rdata_d = {16'b0, div_q};
        default:     rdata_d = irqen_rd;
      endcase
    end
  end

  // All datapath and FSM registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q      <= DIV_RESET;
      flags_q    <= '0;
      rdata_q    <= '0;
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_RESET;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_out_q   <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_RESET;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_prev_q  <= 1'b1;
      rx_brk_q   <= 1'b0;
    end else begin
      div_q      <= div_d;
      flags_q    <= flags_d;
      rdata_q    <= rdata_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_out_q   <= tx_out_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_prev_q  <= uart_rx;
      rx_brk_q   <= rx_brk_d;
    end
  end

  assign uart_tx   = tx_out_q;
  assign mem_rdata = rdata_q;

`ifdef UART_IRQ_EN
  logic [2:0] irqen_q, irqen_d;
  logic       irq_q, irq_d;

  // Interrupt enable register and registered level interrupt
  always_comb begin
    irqen_d = irqen_q;
    if (bus_wr && reg_off == UART_IRQEN) irqen_d = mem_wdata[2:0];
    irq_d    = |(irqen_q & {|flags_q, tx_idle, rx_valid});
    irqen_rd = {29'b0, irqen_q};
  end

  // Interrupt registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      irqen_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      irqen_q <= irqen_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irqen_rd = '0;
  assign irq      = 1'b0;
`endif

endmodule
